// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matmul datapath.
// Holds the broadcast-buffer bank state, the per-vector configuration
// record and the small helpers used by the buffer controller.
package matmul_pkg;

    localparam int unsigned BcNrLanes = 4;
    localparam int unsigned BcMaxBlen = 64;
    localparam int unsigned BcVlenW   = $clog2(BcMaxBlen + 1);
    localparam int unsigned BcReuseW  = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } bc_bank_state_e;

    typedef struct packed {
        logic [BcVlenW-1:0]  vlen;
        logic [BcReuseW-1:0] reuse;
    } bc_cfg_t;

    // A reuse count of zero still means one full read pass.
    function automatic logic [BcReuseW-1:0] bc_norm_reuse(input logic [BcReuseW-1:0] r);
        return (r == '0) ? BcReuseW'(1) : r;
    endfunction

    function automatic logic [1:0] bc_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bc_bank_tracker.sv
// bc_bank_tracker: state of one broadcast-buffer bank.
// Tracks the bank through fill and drain, holding its configuration,
// the number of elements written so far, the read element index and the
// read pass index. All qualification (which bank is addressed) is done
// by the caller; inputs here already target this bank.
//
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   cfg_we_i, cfg_i accept a new configuration (only acted on when EMPTY)
//   push_i          one write beat granted into this bank
//   pop_i           one element consumed from this bank
//   inval_i         discard this bank's contents
//   state_o         current bank state
//   last_beat_o     the current write beat completes the vector
//   last_elem_o     the current read element is the last of a pass
//   last_pass_o     the current pass is the final one
//
// state   | meaning
// --------+----------------------------------------------
// EMPTY   | no vector; waiting for a configuration
// FILLING | configured; accepting write beats
// READY   | fully written; serving elements to lane0
module bc_bank_tracker
    import matmul_pkg::*;
#(
    parameter int unsigned NrLanes = BcNrLanes
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           cfg_we_i,
    input  bc_cfg_t        cfg_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic           inval_i,
    output bc_bank_state_e state_o,
    output logic           last_beat_o,
    output logic           last_elem_o,
    output logic           last_pass_o
);

    // One extra bit so the written count plus a beat never wraps.
    localparam int unsigned CntW = BcVlenW + 1;
    localparam logic [CntW-1:0] BeatElems = CntW'(NrLanes);

    bc_bank_state_e        state_q, state_d;
    bc_cfg_t               cfg_q, cfg_d;
    logic [CntW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [BcVlenW-1:0]    elem_cnt_q, elem_cnt_d;
    logic [BcReuseW-1:0]   pass_q, pass_d;

    logic last_beat, last_elem, last_pass;

    // A partial final beat counts as the last one.
    assign last_beat = (wr_cnt_q + BeatElems) >= {1'b0, cfg_q.vlen};
    assign last_elem = elem_cnt_q == (cfg_q.vlen - BcVlenW'(1));
    assign last_pass = pass_q == (cfg_q.reuse - BcReuseW'(1));

    assign state_o     = state_q;
    assign last_beat_o = last_beat;
    assign last_elem_o = last_elem;
    assign last_pass_o = last_pass;

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        wr_cnt_d   = wr_cnt_q;
        elem_cnt_d = elem_cnt_q;
        pass_d     = pass_q;
        case (state_q)
            EMPTY: begin
                if (cfg_we_i) begin
                    cfg_d.vlen  = cfg_i.vlen;
                    cfg_d.reuse = bc_norm_reuse(cfg_i.reuse);
                    wr_cnt_d    = '0;
                    elem_cnt_d  = '0;
                    pass_d      = '0;
                    state_d     = FILLING;
                end
            end
            FILLING: begin
                if (push_i) begin
                    if (last_beat) state_d = READY;
                    else           wr_cnt_d = wr_cnt_q + BeatElems;
                end
            end
            READY: begin
                // Invalidate wins over a simultaneous pop.
                if (inval_i) begin
                    state_d = EMPTY;
                end else if (pop_i) begin
                    if (last_elem) begin
                        if (last_pass) begin
                            state_d = EMPTY;
                        end else begin
                            elem_cnt_d = '0;
                            pass_d     = pass_q + BcReuseW'(1);
                        end
                    end else begin
                        elem_cnt_d = elem_cnt_q + BcVlenW'(1);
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            cfg_q      <= '0;
            wr_cnt_q   <= '0;
            elem_cnt_q <= '0;
            pass_q     <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            wr_cnt_q   <= wr_cnt_d;
            elem_cnt_q <= elem_cnt_d;
            pass_q     <= pass_d;
        end
    end

endmodule

// File: rtl/bc_buffer_ctrl.sv
// bc_buffer_ctrl: ping-pong sequencer for the lane0 broadcast buffer.
// Configurations and load-unit beats go into the write bank; lane0 reads
// the read bank, repeating it for the configured number of passes before
// releasing it. The two banks alternate so filling overlaps draining.
//
// Ports:
//   cfg_*            configuration handshake (vlen, reuse)
//   ldu_req_i/gnt_o  load-unit write handshake, all lanes granted together
//   ldu_final_gnt_o  grant of the beat that completes the vector
//   buf_*_o          per-bank push / final push / pop / rewind / flush
//   rd_bank_o        bank select for the read data mux
//   bc_data_*        element stream to lane0, bc_last_o ends each pass
//   bc_data_invalidate_i  lane0 drops the current read bank
module bc_buffer_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned MaxBlen = 64,
    parameter int unsigned ReuseW  = 8,
    parameter int unsigned VlenW   = $clog2(MaxBlen + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [VlenW-1:0]   cfg_vlen_i,
    input  logic [ReuseW-1:0]  cfg_reuse_i,
    input  logic [NrLanes-1:0] ldu_req_i,
    output logic [NrLanes-1:0] ldu_gnt_o,
    output logic [NrLanes-1:0] ldu_final_gnt_o,
    output logic [1:0]         buf_push_o,
    output logic [1:0]         buf_final_push_o,
    output logic [1:0]         buf_pop_o,
    output logic [1:0]         buf_rewind_o,
    output logic [1:0]         buf_flush_o,
    output logic               rd_bank_o,
    output logic               bc_data_valid_o,
    input  logic               bc_data_ready_i,
    output logic               bc_last_o,
    input  logic               bc_data_invalidate_i
);

    if ((MaxBlen % NrLanes) != 0) begin : g_bad_blen
        $error("MaxBlen must be a multiple of NrLanes");
    end
    if (VlenW != BcVlenW || ReuseW != BcReuseW) begin : g_bad_width
        $error("bc_buffer_ctrl widths must match matmul_pkg");
    end

    logic write_id_q, write_id_d;
    logic read_id_q, read_id_d;

    bc_bank_state_e bank_state [2];
    logic [1:0]     last_beat, last_elem, last_pass;

    bc_cfg_t cfg;
    logic    cfg_acc, gnt, final_beat, valid, inval, pop, pass_end, rewind, flush;

    assign cfg.vlen  = BcVlenW'(cfg_vlen_i);
    assign cfg.reuse = BcReuseW'(cfg_reuse_i);

    assign cfg_ready_o = bank_state[write_id_q] == EMPTY;
    // A zero-length vector is handshaken but never reaches the bank.
    assign cfg_acc     = cfg_valid_i && cfg_ready_o && (cfg_vlen_i != '0);

    assign gnt        = (bank_state[write_id_q] == FILLING) && (&ldu_req_i);
    assign final_beat = gnt && last_beat[write_id_q];

    assign valid    = bank_state[read_id_q] == READY;
    assign inval    = valid && bc_data_invalidate_i;
    assign pop      = valid && bc_data_ready_i && !inval;
    assign pass_end = pop && last_elem[read_id_q];
    assign rewind   = pass_end && !last_pass[read_id_q];
    assign flush    = (pass_end && last_pass[read_id_q]) || inval;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bc_bank_tracker #(
            .NrLanes(NrLanes)
        ) i_bank (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .cfg_we_i   (cfg_acc && (write_id_q == 1'(b))),
            .cfg_i      (cfg),
            .push_i     (gnt && (write_id_q == 1'(b))),
            .pop_i      (pop && (read_id_q == 1'(b))),
            .inval_i    (inval && (read_id_q == 1'(b))),
            .state_o    (bank_state[b]),
            .last_beat_o(last_beat[b]),
            .last_elem_o(last_elem[b]),
            .last_pass_o(last_pass[b])
        );
    end

    always_comb begin
        write_id_d = write_id_q ^ final_beat;
        read_id_d  = read_id_q ^ flush;

        ldu_gnt_o        = {NrLanes{gnt}};
        ldu_final_gnt_o  = {NrLanes{final_beat}};
        buf_push_o       = gnt ? bc_onehot(write_id_q) : 2'b00;
        buf_final_push_o = final_beat ? bc_onehot(write_id_q) : 2'b00;
        buf_pop_o        = pop ? bc_onehot(read_id_q) : 2'b00;
        buf_rewind_o     = rewind ? bc_onehot(read_id_q) : 2'b00;
        buf_flush_o      = flush ? bc_onehot(read_id_q) : 2'b00;
        rd_bank_o        = read_id_q;
        bc_data_valid_o  = valid;
        bc_last_o        = valid && last_elem[read_id_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_id_q <= 1'b0;
            read_id_q  <= 1'b0;
        end else begin
            write_id_q <= write_id_d;
            read_id_q  <= read_id_d;
        end
    end

    a_vlen_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cfg_valid_i |-> (cfg_vlen_i <= VlenW'(MaxBlen)));

    a_push_pop_disjoint: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (buf_push_o & buf_pop_o) == 2'b00);

endmodule

// File: tb/tb_bc_buffer_ctrl.sv
module tb_bc_buffer_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [6:0] cfg_vlen_i;
    logic [7:0] cfg_reuse_i;
    logic [3:0] ldu_req_i;
    logic [3:0] ldu_gnt_o;
    logic [3:0] ldu_final_gnt_o;
    logic [1:0] buf_push_o;
    logic [1:0] buf_final_push_o;
    logic [1:0] buf_pop_o;
    logic [1:0] buf_rewind_o;
    logic [1:0] buf_flush_o;
    logic       rd_bank_o;
    logic       bc_data_valid_o;
    logic       bc_data_ready_i;
    logic       bc_last_o;
    logic       bc_data_invalidate_i;

    bc_buffer_ctrl dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .cfg_valid_i         (cfg_valid_i),
        .cfg_ready_o         (cfg_ready_o),
        .cfg_vlen_i          (cfg_vlen_i),
        .cfg_reuse_i         (cfg_reuse_i),
        .ldu_req_i           (ldu_req_i),
        .ldu_gnt_o           (ldu_gnt_o),
        .ldu_final_gnt_o     (ldu_final_gnt_o),
        .buf_push_o          (buf_push_o),
        .buf_final_push_o    (buf_final_push_o),
        .buf_pop_o           (buf_pop_o),
        .buf_rewind_o        (buf_rewind_o),
        .buf_flush_o         (buf_flush_o),
        .rd_bank_o           (rd_bank_o),
        .bc_data_valid_o     (bc_data_valid_o),
        .bc_data_ready_i     (bc_data_ready_i),
        .bc_last_o           (bc_last_o),
        .bc_data_invalidate_i(bc_data_invalidate_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       bank;
        logic       last;
        logic [1:0] rew;
        logic [1:0] fl;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      n_checks = 0;
    int      n_errors = 0;
    logic    exp_wr   = 1'b0;

    // Reset value: only cfg_ready_o (the MSB) is high.
    localparam logic [21:0] RstOuts = 22'h200000;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [21:0] out_vec();
        return {cfg_ready_o, ldu_gnt_o, ldu_final_gnt_o, buf_push_o, buf_final_push_o,
                buf_pop_o, buf_rewind_o, buf_flush_o, rd_bank_o, bc_data_valid_o, bc_last_o};
    endfunction

    task automatic sample_read();
        rd_exp_t e;
        if (bc_data_valid_o && bc_data_ready_i && !bc_data_invalidate_i) begin
            if (rd_q.size() == 0) begin
                check_eq("rd_unexpected_pop", int'(bc_data_valid_o), 0);
            end else begin
                e = rd_q.pop_front();
                check_eq("rd_pop", int'({rd_bank_o, bc_last_o, buf_rewind_o, buf_flush_o, buf_pop_o}),
                         int'({e.bank, e.last, e.rew, e.fl, oh(e.bank)}));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        sample_read();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cfg_valid_i = 1'b0; cfg_vlen_i = '0; cfg_reuse_i = '0;
        ldu_req_i = '0; bc_data_ready_i = 1'b0; bc_data_invalidate_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        rd_q.delete();
        exp_wr = 1'b0;
    endtask

    task automatic do_cfg(input int vlen, input int reuse);
        rd_exp_t e;
        int r;
        for (int i = 0; i < 100 && !cfg_ready_o; i++) tick();
        check_eq("cfg_ready_wait", int'(cfg_ready_o), 1);
        r = (reuse == 0) ? 1 : reuse;
        for (int p = 0; p < r; p++) begin
            for (int k = 0; k < vlen; k++) begin
                e.bank = exp_wr;
                e.last = (k == vlen - 1);
                e.rew  = (k == vlen - 1 && p < r - 1) ? oh(exp_wr) : 2'b00;
                e.fl   = (k == vlen - 1 && p == r - 1) ? oh(exp_wr) : 2'b00;
                rd_q.push_back(e);
            end
        end
        cfg_valid_i = 1'b1;
        cfg_vlen_i  = 7'(vlen);
        cfg_reuse_i = 8'(reuse);
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic fill(input int nbeats);
        logic last;
        ldu_req_i = 4'hF;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk_i);
            last = (b == nbeats - 1);
            check_eq("wr_gnt", int'({ldu_gnt_o, ldu_final_gnt_o}),
                     int'({4'hF, last ? 4'hF : 4'h0}));
            check_eq("wr_push", int'({buf_push_o, buf_final_push_o}),
                     int'({oh(exp_wr), last ? oh(exp_wr) : 2'b00}));
            sample_read();
            @(posedge clk_i);
            #1;
        end
        ldu_req_i = '0;
        exp_wr = ~exp_wr;
    endtask

    task automatic drain(input int remain, input int budget);
        for (int i = 0; i < budget && rd_q.size() > remain; i++) tick();
        check_eq("drain_left", rd_q.size(), remain);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        cfg_valid_i = 1'b0; cfg_vlen_i = '0; cfg_reuse_i = '0;
        ldu_req_i = '0; bc_data_ready_i = 1'b0; bc_data_invalidate_i = 1'b0;
        #1;
        check_eq("reset_outs", int'(out_vec()), int'(RstOuts));
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check_eq("post_reset_outs", int'(out_vec()), int'(RstOuts));

        // vlen=8, reuse=1
        do_cfg(8, 1);
        fill(2);
        bc_data_ready_i = 1'b1;
        drain(0, 50);
        check_eq("t1_idle", int'({bc_data_valid_o, cfg_ready_o}), int'(2'b01));
        bc_data_ready_i = 1'b0;

        // vlen=6, reuse=3: partial last beat, two rewinds
        do_reset();
        do_cfg(6, 3);
        fill(2);
        bc_data_ready_i = 1'b1;
        drain(0, 100);
        check_eq("t2_idle", int'({bc_data_valid_o, cfg_ready_o}), int'(2'b01));
        bc_data_ready_i = 1'b0;

        // Ping-pong: B fills bank 1 while A drains bank 0
        do_reset();
        do_cfg(4, 2);
        fill(1);
        bc_data_ready_i = 1'b1;
        do_cfg(4, 1);
        fill(1);
        drain(4, 50);
        check_eq("pp_b_valid_next", int'({bc_data_valid_o, rd_bank_o}), int'(2'b11));
        drain(0, 50);
        bc_data_ready_i = 1'b0;

        // Invalidate after 3 of 8 pops
        do_reset();
        do_cfg(8, 1);
        fill(2);
        bc_data_ready_i = 1'b1;
        repeat (3) tick();
        check_eq("inv_pre_pops", rd_q.size(), 5);
        bc_data_invalidate_i = 1'b1;
        @(negedge clk_i);
        check_eq("inv_flush", int'({buf_flush_o, buf_pop_o, buf_rewind_o}), int'(6'b01_00_00));
        sample_read();
        @(posedge clk_i);
        #1;
        bc_data_invalidate_i = 1'b0;
        bc_data_ready_i = 1'b0;
        rd_q.delete();
        check_eq("inv_rd_id", int'({rd_bank_o, bc_data_valid_o, cfg_ready_o}), int'(3'b101));
        bc_data_invalidate_i = 1'b1;
        @(negedge clk_i);
        check_eq("inv_noop", int'({buf_flush_o, buf_pop_o}), 0);
        @(posedge clk_i);
        #1;
        bc_data_invalidate_i = 1'b0;
        check_eq("inv_noop_state", int'({rd_bank_o, bc_data_valid_o, cfg_ready_o}), int'(3'b101));
        do_cfg(4, 1);
        fill(1);
        bc_data_ready_i = 1'b1;
        drain(0, 50);
        bc_data_ready_i = 1'b0;

        // Both banks READY: writes stall until a bank is freed
        do_reset();
        do_cfg(4, 1);
        fill(1);
        do_cfg(4, 1);
        fill(1);
        check_eq("both_rdy_cfg_ready", int'(cfg_ready_o), 0);
        ldu_req_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq("both_rdy_gnt", int'({ldu_gnt_o, buf_push_o}), 0);
            @(posedge clk_i);
            #1;
        end
        bc_data_ready_i = 1'b1;
        drain(4, 50);
        bc_data_ready_i = 1'b0;
        check_eq("freed_bank", int'({cfg_ready_o, ldu_gnt_o}), int'(5'b1_0000));
        cfg_valid_i = 1'b1;
        cfg_vlen_i  = '0;
        cfg_reuse_i = 8'd1;
        tick();
        cfg_valid_i = 1'b0;
        check_eq("vlen0_noop", int'({cfg_ready_o, ldu_gnt_o, bc_data_valid_o, rd_bank_o}),
                 int'(7'b1_0000_11));
        do_cfg(4, 1);
        fill(1);
        bc_data_ready_i = 1'b1;
        drain(0, 50);
        bc_data_ready_i = 1'b0;

        // Reset mid-fill, then a fresh vector (reuse 0 acts as 1)
        do_reset();
        do_cfg(8, 1);
        ldu_req_i = 4'hF;
        @(negedge clk_i);
        check_eq("rst_beat1_gnt", int'({ldu_gnt_o, ldu_final_gnt_o}), int'(8'hF0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("rst_mid_outs", int'(out_vec()), int'(RstOuts));
        ldu_req_i = '0;
        rd_q.delete();
        exp_wr = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        do_cfg(4, 0);
        fill(1);
        bc_data_ready_i = 1'b1;
        drain(0, 50);
        check_eq("rst_fresh_idle", int'({bc_data_valid_o, cfg_ready_o, rd_bank_o}), int'(3'b011));
        bc_data_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
